hazard_scoreboard: RTL and testbench

Parametrised successor to the pipeline's load/use and RAW hazard detector. It keeps a per-register countdown scoreboard of in-flight writes, each with its own producer latency. This lets one block serve the forwarding and non-forwarding pipeline variants, and multi-cycle producers such as MUL/DIV. It sits beside the ID stage: it tracks instructions as they leave ID and stalls ID while a source register is not yet readable or forwardable.

---
 rtl/hazard_scoreboard.sv | 85 ++++++++
 tb/tb_hazard_scoreboard.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// Per-register countdown scoreboard that stalls ID on RAW/load-use hazards.
// Define HAZARD_STATS_EN to add the stall_cycles / raw_events counters.
module hazard_scoreboard #(
  parameter int NUM_REGS   = 32,
  parameter int REG_ADDR_W = 5,
  parameter int LAT_W      = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic                  flush,
  input  logic [REG_ADDR_W-1:0] rs1_id,
  input  logic [REG_ADDR_W-1:0] rs2_id,
  input  logic                  use_rs1,
  input  logic                  use_rs2,
  input  logic [REG_ADDR_W-1:0] rd_id,
  input  logic                  reg_write_id,
  input  logic [LAT_W-1:0]      lat_id,
  output logic                  is_stall,
  output logic                  stall_rs1,
  output logic                  stall_rs2,
  output logic [NUM_REGS-1:0]   pending_mask
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]           stall_cycles,
  output logic [31:0]           raw_events
`endif
);

  logic [LAT_W-1:0] cnt [NUM_REGS];
  logic             rs1_pend;
  logic             rs2_pend;
  logic             fire;

  function automatic logic [LAT_W-1:0] dec_sat(input logic [LAT_W-1:0] c);
    return (c == '0) ? '0 : c - LAT_W'(1);
  endfunction

  // Lookup by comparison rather than indexing so out-of-range sources read as not pending.
  always_comb begin
    pending_mask = '0;
    rs1_pend     = 1'b0;
    rs2_pend     = 1'b0;
    for (int unsigned r = 1; r < NUM_REGS; r++) begin
      pending_mask[r] = (cnt[r] != '0);
      if (rs1_id == REG_ADDR_W'(r)) rs1_pend = (cnt[r] != '0);
      if (rs2_id == REG_ADDR_W'(r)) rs2_pend = (cnt[r] != '0);
    end
  end

  assign stall_rs1 = id_valid & use_rs1 & rs1_pend;
  assign stall_rs2 = id_valid & use_rs2 & rs2_pend;
  assign is_stall  = stall_rs1 | stall_rs2;
  assign fire      = id_valid & ~is_stall & ~flush & reg_write_id & (rd_id != '0);

  always_ff @(posedge clk) begin
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      if (reset || r == 0) begin
        cnt[r] <= '0;
      end else if (fire && rd_id == REG_ADDR_W'(r)) begin
        // WAW: keep whichever outstanding write finishes last.
        cnt[r] <= (dec_sat(cnt[r]) > lat_id) ? dec_sat(cnt[r]) : lat_id;
      end else begin
        cnt[r] <= dec_sat(cnt[r]);
      end
    end
  end

`ifdef HAZARD_STATS_EN
  logic stall_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q      <= 1'b0;
      stall_cycles <= '0;
      raw_events   <= '0;
    end else begin
      stall_q <= is_stall;
      if (is_stall && stall_cycles != '1) stall_cycles <= stall_cycles + 32'd1;
      if (is_stall && !stall_q && raw_events != '1) raw_events <= raw_events + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios plus a randomized
// run against a release-time model of the scoreboard.
module tb_hazard_scoreboard;
  localparam int NR = 24;
  localparam int AW = 5;
  localparam int LW = 3;

  logic          clk = 1'b0;
  logic          reset, id_valid, flush, use_rs1, use_rs2, reg_write_id;
  logic [AW-1:0] rs1_id, rs2_id, rd_id;
  logic [LW-1:0] lat_id;
  logic          is_stall, stall_rs1, stall_rs2;
  logic [NR-1:0] pending_mask;
`ifdef HAZARD_STATS_EN
  logic [31:0]   stall_cycles, raw_events;
`endif

  hazard_scoreboard #(.NUM_REGS(NR), .REG_ADDR_W(AW), .LAT_W(LW)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .flush(flush),
    .rs1_id(rs1_id), .rs2_id(rs2_id), .use_rs1(use_rs1), .use_rs2(use_rs2),
    .rd_id(rd_id), .reg_write_id(reg_write_id), .lat_id(lat_id),
    .is_stall(is_stall), .stall_rs1(stall_rs1), .stall_rs2(stall_rs2),
    .pending_mask(pending_mask)
`ifdef HAZARD_STATS_EN
    , .stall_cycles(stall_cycles), .raw_events(raw_events)
`endif
  );

  always #5 clk = ~clk;

  // Model: rel[r] is the edge count at which register r stops being pending.
  int     rel [NR];
  int     edge_n = 0;
  longint m_sc = 0, m_raw = 0;
  bit     m_prev = 1'b0;
  int     n_checks = 0, n_fail = 0;
  logic [NR-1:0] em;

  function automatic bit m_pend(logic [AW-1:0] r);
    int ri;
    ri = int'(r);
    return ri != 0 && ri < NR && edge_n < rel[ri];
  endfunction

  function automatic bit m_s1();
    return id_valid && use_rs1 && m_pend(rs1_id);
  endfunction

  function automatic bit m_s2();
    return id_valid && use_rs2 && m_pend(rs2_id);
  endfunction

  function automatic logic [NR-1:0] m_mask();
    logic [NR-1:0] m;
    m = '0;
    for (int r = 1; r < NR; r++) m[r] = (edge_n < rel[r]);
    return m;
  endfunction

  task automatic set_in(bit v, bit fl, int r1, bit u1, int r2, bit u2, int rd, bit wr, int lat);
    id_valid = v; flush = fl;
    rs1_id = r1[AW-1:0]; use_rs1 = u1;
    rs2_id = r2[AW-1:0]; use_rs2 = u2;
    rd_id = rd[AW-1:0]; reg_write_id = wr; lat_id = lat[LW-1:0];
  endtask

  task automatic tick();
    bit st, f;
    st = m_s1() || m_s2();
    f  = id_valid && !st && !flush && reg_write_id && rd_id != '0 && int'(rd_id) < NR;
    @(posedge clk);
    edge_n++;
    if (reset) begin
      for (int r = 0; r < NR; r++) rel[r] = edge_n;
      m_sc = 0; m_raw = 0; m_prev = 1'b0;
    end else begin
      if (st) m_sc++;
      if (st && !m_prev) m_raw++;
      m_prev = st;
      if (f && rel[int'(rd_id)] < edge_n + int'(lat_id)) rel[int'(rd_id)] = edge_n + int'(lat_id);
    end
    #1;
  endtask

  task automatic idle(int n);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_in(1, 0, $urandom_range(31), 1, $urandom_range(31), 1, $urandom_range(31), 1, $urandom_range(7));
      tick();
      set_in(1, 0, $urandom_range(31), 1, $urandom_range(31), 1, 0, 0, 0);
      #1;
      n_checks++;
      if (pending_mask !== '0) begin n_fail++; $display("FAIL reset_mask: got %h exp 0", pending_mask); end
      n_checks++;
      if (is_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b exp 0", is_stall); end
    end
    reset = 1'b0;
    idle(1);
  endtask

  task automatic test_raw_basic();
    set_in(1, 0, 0, 0, 0, 0, 5, 1, 2);
    tick();
    set_in(1, 0, 5, 1, 0, 0, 0, 0, 0);
    em = '0; em[5] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (is_stall !== (i < 2)) begin n_fail++; $display("FAIL raw_stall[%0d]: got %b exp %b", i, is_stall, i < 2); end
      n_checks++;
      if (stall_rs1 !== (i < 2) || stall_rs2 !== 1'b0) begin
        n_fail++; $display("FAIL raw_srcs[%0d]: got rs1=%b rs2=%b exp rs1=%b rs2=0", i, stall_rs1, stall_rs2, i < 2);
      end
      n_checks++;
      if (pending_mask !== ((i < 2) ? em : '0)) begin n_fail++; $display("FAIL raw_mask[%0d]: got %h", i, pending_mask); end
      tick();
    end
    idle(2);
  endtask

  task automatic test_x0_zero_lat();
    set_in(1, 0, 0, 0, 0, 0, 0, 1, 7);
    tick();
    #1;
    n_checks++;
    if (pending_mask !== '0) begin n_fail++; $display("FAIL x0_mask: got %h exp 0", pending_mask); end
    set_in(1, 0, 0, 0, 0, 0, 9, 1, 0);
    tick();
    set_in(1, 0, 9, 1, 9, 1, 0, 0, 0);
    #1;
    n_checks++;
    if (is_stall !== 1'b0 || pending_mask !== '0) begin
      n_fail++; $display("FAIL lat0: got stall=%b mask=%h exp 0/0", is_stall, pending_mask);
    end
    idle(2);
  endtask

  task automatic test_waw();
    for (int k = 0; k < 2; k++) begin
      int exp_n;
      exp_n = (k == 0) ? 2 : 4;
      set_in(1, 0, 0, 0, 0, 0, 7, 1, 3);
      tick();
      set_in(1, 0, 0, 0, 0, 0, 7, 1, (k == 0) ? 1 : 4);
      tick();
      set_in(1, 0, 7, 1, 0, 0, 0, 0, 0);
      for (int i = 0; i <= exp_n; i++) begin
        #1;
        n_checks++;
        if (is_stall !== (i < exp_n)) begin
          n_fail++; $display("FAIL waw%0d_stall[%0d]: got %b exp %b", k, i, is_stall, i < exp_n);
        end
        tick();
      end
      idle(1);
    end
  endtask

  task automatic test_flush();
    set_in(1, 1, 0, 0, 0, 0, 4, 1, 2);
    tick();
    #1;
    n_checks++;
    if (pending_mask !== '0) begin n_fail++; $display("FAIL flush_mask: got %h exp 0", pending_mask); end
    set_in(1, 0, 0, 0, 0, 0, 4, 1, 2);
    tick();
    set_in(1, 0, 0, 0, 4, 0, 0, 0, 0);
    #1;
    n_checks++;
    if (is_stall !== 1'b0) begin n_fail++; $display("FAIL unused_rs2: got %b exp 0", is_stall); end
    set_in(1, 1, 0, 0, 4, 1, 0, 0, 0);
    #1;
    n_checks++;
    if (is_stall !== 1'b1 || stall_rs2 !== 1'b1 || stall_rs1 !== 1'b0) begin
      n_fail++; $display("FAIL flush_no_mask: got stall=%b rs1=%b rs2=%b exp 1/0/1", is_stall, stall_rs1, stall_rs2);
    end
    idle(3);
  endtask

  task automatic test_same_src();
    set_in(1, 0, 0, 0, 0, 0, 11, 1, 3);
    tick();
    set_in(1, 0, 11, 1, 11, 1, 0, 0, 0);
    #1;
    n_checks++;
    if (stall_rs1 !== 1'b1 || stall_rs2 !== 1'b1) begin
      n_fail++; $display("FAIL same_src: got rs1=%b rs2=%b exp 1/1", stall_rs1, stall_rs2);
    end
    idle(4);
  endtask

  task automatic test_back_to_back();
    set_in(1, 0, 0, 0, 0, 0, 5, 1, 1);
    tick();
    set_in(1, 0, 5, 1, 0, 0, 6, 1, 3);
    #1;
    n_checks++;
    if (is_stall !== 1'b1) begin n_fail++; $display("FAIL b2b_stall: got %b exp 1", is_stall); end
    tick();
    #1;
    n_checks++;
    if (is_stall !== 1'b0 || pending_mask !== '0) begin
      n_fail++; $display("FAIL b2b_release: got stall=%b mask=%h exp 0/0", is_stall, pending_mask);
    end
    tick();
    em = '0; em[6] = 1'b1;
    n_checks++;
    if (pending_mask !== em) begin n_fail++; $display("FAIL b2b_issue: got %h exp %h", pending_mask, em); end
    idle(4);
  endtask

  task automatic test_reset_midop();
    set_in(1, 0, 0, 0, 0, 0, 3, 1, 2);
    tick();
    em = '0; em[3] = 1'b1;
    n_checks++;
    if (pending_mask !== em) begin n_fail++; $display("FAIL midop_pre: got %h exp %h", pending_mask, em); end
    reset = 1'b1;
    set_in(1, 0, 0, 0, 0, 0, 3, 1, 7);
    tick();
    reset = 1'b0;
    set_in(1, 0, 3, 1, 3, 1, 0, 0, 0);
    #1;
    n_checks++;
    if (pending_mask !== '0 || is_stall !== 1'b0) begin
      n_fail++; $display("FAIL midop_reset: got mask=%h stall=%b exp 0/0", pending_mask, is_stall);
    end
    idle(1);
  endtask

  task automatic test_range();
    set_in(1, 0, 0, 0, 0, 0, 25, 1, 5);
    tick();
    set_in(1, 0, 25, 1, 30, 1, 23, 1, 2);
    #1;
    n_checks++;
    if (pending_mask !== '0 || is_stall !== 1'b0) begin
      n_fail++; $display("FAIL oor: got mask=%h stall=%b exp 0/0", pending_mask, is_stall);
    end
    tick();
    em = '0; em[NR-1] = 1'b1;
    n_checks++;
    if (pending_mask !== em) begin n_fail++; $display("FAIL top_reg: got %h exp %h", pending_mask, em); end
    idle(3);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(49) == 0);
      set_in($urandom_range(3) != 0, $urandom_range(7) == 0,
             $urandom_range(31), $urandom_range(1), $urandom_range(31), $urandom_range(1),
             $urandom_range(31), $urandom_range(3) != 0, $urandom_range(7));
      #1;
      n_checks++;
      if (is_stall !== (m_s1() || m_s2()) || stall_rs1 !== m_s1() || stall_rs2 !== m_s2()) begin
        n_fail++; $display("FAIL rand_stall[%0d]: got %b%b%b exp %b%b%b", i, is_stall, stall_rs1, stall_rs2,
                           m_s1() || m_s2(), m_s1(), m_s2());
      end
      n_checks++;
      if (pending_mask !== m_mask()) begin n_fail++; $display("FAIL rand_mask[%0d]: got %h exp %h", i, pending_mask, m_mask()); end
`ifdef HAZARD_STATS_EN
      n_checks++;
      if (stall_cycles !== 32'(m_sc) || raw_events !== 32'(m_raw)) begin
        n_fail++; $display("FAIL rand_stats[%0d]: got %0d/%0d exp %0d/%0d", i, stall_cycles, raw_events, m_sc, m_raw);
      end
`endif
      tick();
    end
    reset = 1'b0;
    idle(8);
  endtask

`ifdef HAZARD_STATS_EN
  task automatic test_stats();
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      set_in(1, 0, 0, 0, 0, 0, 5 + k, 1, 2);
      tick();
      set_in(1, 0, 5 + k, 1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) tick();
      idle(1);
    end
    n_checks++;
    if (stall_cycles !== 32'd4 || raw_events !== 32'd2) begin
      n_fail++; $display("FAIL stats: got cycles=%0d events=%0d exp 4/2", stall_cycles, raw_events);
    end
  endtask
`endif

  initial begin
    reset = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int r = 0; r < NR; r++) rel[r] = 0;
    test_reset();
    test_raw_basic();
    test_x0_zero_lat();
    test_waw();
    test_flush();
    test_same_src();
    test_back_to_back();
    test_reset_midop();
    test_range();
    test_random();
`ifdef HAZARD_STATS_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
